// File: rtl/axis_icrc_strip.sv
// Strips the trailing 4-byte RoCEv2 ICRC from an AXI-Stream frame and reports it on a sideband.
// Optional build macro ICRC_CHECK_EN adds an external-calc compare that gates the last output beat.
module axis_icrc_strip #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic [31:0]               m_icrc,
    output logic                      m_icrc_valid,
`ifdef ICRC_CHECK_EN
    input  logic [31:0]               s_icrc_calc,
    input  logic                      s_icrc_calc_valid,
    output logic                      m_icrc_bad,
`endif
    output logic                      m_runt
);

    localparam int KB = DATA_WIDTH / 8;
    localparam int BW = 32 + USER_WIDTH + 1 + KB + DATA_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FULL = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    function automatic int unsigned popcnt(input logic [KB-1:0] k);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < KB; i++) c += 32'(k[i]);
        return c;
    endfunction

    function automatic logic [KB-1:0] lowmask(input int unsigned c);
        logic [KB-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < KB; i++) m[i] = (i < c);
        return m;
    endfunction

    function automatic logic [31:0] tail_icrc(input logic [DATA_WIDTH-1:0] d, input int unsigned n);
        logic [DATA_WIDTH-1:0] sh;
        sh = d >> (8 * (n - 4));
        return sh[31:0];
    endfunction

    // ICRC split across beats: top (4-n) held bytes first, then the n bytes of the last beat.
    function automatic logic [31:0] split_icrc(input logic [DATA_WIDTH-1:0] hd, input int unsigned hn,
                                               input logic [31:0] nd, input int unsigned n);
        logic [DATA_WIDTH-1:0] lo;
        lo = hd >> (8 * (hn - (4 - n)));
        return (lo[31:0] & (32'hFFFF_FFFF >> (8 * n))) | (nd << (8 * (4 - n)));
    endfunction

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [KB-1:0]         hold_keep_q, hold_keep_d;
    logic [USER_WIDTH-1:0] hold_user_q, hold_user_d;
    logic                  hold_first_q, hold_first_d;
    logic [31:0]           hold_icrc_q, hold_icrc_d;
    logic [USER_WIDTH-1:0] frame_user_q, frame_user_d, last_user;
    logic                  s_ready_q, ready_int_q, ready_early;
    logic                  runt_q, runt_d;
    logic                  in_acc;
    int unsigned           in_n, hold_n;

    logic                  push_valid, push_last;
    logic [DATA_WIDTH-1:0] push_data;
    logic [KB-1:0]         push_keep;
    logic [USER_WIDTH-1:0] push_user;
    logic [31:0]           push_icrc;
    logic [BW-1:0]         push_beat, out_beat_q, tmp_beat_q;
    logic                  out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;
    logic                  to_out, to_tmp, tmp_to_out;
    logic                  m_ready_eff, icrc_fire;
    logic [31:0]           icrc_hold_q;

    logic [DATA_WIDTH-1:0] out_data;
    logic [KB-1:0]         out_keep;
    logic                  out_last;
    logic [USER_WIDTH-1:0] out_user;
    logic [31:0]           out_icrc;

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_keep_d  = hold_keep_q;
        hold_user_d  = hold_user_q;
        hold_first_d = hold_first_q;
        hold_icrc_d  = hold_icrc_q;
        frame_user_d = frame_user_q;
        runt_d       = 1'b0;
        push_valid   = 1'b0;
        push_data    = hold_data_q;
        push_keep    = hold_keep_q;
        push_last    = 1'b0;
        push_user    = hold_user_q;
        push_icrc    = hold_icrc_q;
        in_n         = popcnt(s_axis_tkeep);
        hold_n       = popcnt(hold_keep_q);
        in_acc       = s_axis_tvalid && s_ready_q;
        last_user    = frame_user_q | s_axis_tuser;
        case (state_q)
            ST_IDLE: if (in_acc) begin
                if (!s_axis_tlast) begin
                    hold_data_d  = s_axis_tdata;
                    hold_keep_d  = s_axis_tkeep;
                    hold_user_d  = s_axis_tuser;
                    hold_first_d = 1'b1;
                    frame_user_d = s_axis_tuser;
                    state_d      = ST_FULL;
                end else if (in_n > 4) begin
                    push_valid = 1'b1;
                    push_data  = s_axis_tdata;
                    push_keep  = lowmask(in_n - 4);
                    push_last  = 1'b1;
                    push_user  = s_axis_tuser;
                    push_icrc  = tail_icrc(s_axis_tdata, in_n);
                end else begin
                    runt_d = 1'b1;
                end
            end
            ST_FULL: if (in_acc) begin
                push_valid = 1'b1;
                if (!s_axis_tlast) begin
                    hold_data_d  = s_axis_tdata;
                    hold_keep_d  = s_axis_tkeep;
                    hold_user_d  = s_axis_tuser;
                    hold_first_d = 1'b0;
                    frame_user_d = last_user;
                end else if (in_n > 4) begin
                    // Trimmed last beat waits in the hold register for the next push slot.
                    hold_data_d = s_axis_tdata;
                    hold_keep_d = lowmask(in_n - 4);
                    hold_user_d = last_user;
                    hold_icrc_d = tail_icrc(s_axis_tdata, in_n);
                    state_d     = ST_PEND;
                end else if (in_n == 4) begin
                    push_last = 1'b1;
                    push_user = last_user;
                    push_icrc = s_axis_tdata[31:0];
                    state_d   = ST_IDLE;
                end else if (hold_first_q && hold_n <= 4 - in_n) begin
                    push_valid = 1'b0;
                    runt_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    push_last = 1'b1;
                    push_user = last_user;
                    push_keep = lowmask((hold_n > 4 - in_n) ? hold_n - (4 - in_n) : 0);
                    push_icrc = split_icrc(hold_data_q, hold_n, s_axis_tdata[31:0], in_n);
                    state_d   = ST_IDLE;
                end
            end
            ST_PEND: if (ready_int_q) begin
                push_valid = 1'b1;
                push_last  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign push_beat   = {push_icrc, push_user, push_last, push_keep, push_data};
    assign ready_early = m_ready_eff || (!tmp_valid_q && (!out_valid_q || !push_valid));

    always_comb begin
        out_valid_d = out_valid_q;
        tmp_valid_d = tmp_valid_q;
        to_out      = 1'b0;
        to_tmp      = 1'b0;
        tmp_to_out  = 1'b0;
        if (ready_int_q) begin
            if (m_ready_eff || !out_valid_q) begin
                out_valid_d = push_valid;
                to_out      = 1'b1;
            end else begin
                tmp_valid_d = push_valid;
                to_tmp      = 1'b1;
            end
        end else if (m_ready_eff) begin
            out_valid_d = tmp_valid_q;
            tmp_valid_d = 1'b0;
            tmp_to_out  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            hold_user_q  <= '0;
            hold_first_q <= 1'b0;
            hold_icrc_q  <= '0;
            frame_user_q <= '0;
            s_ready_q    <= 1'b0;
            ready_int_q  <= 1'b0;
            runt_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            tmp_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            tmp_beat_q   <= '0;
            icrc_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_keep_q  <= hold_keep_d;
            hold_user_q  <= hold_user_d;
            hold_first_q <= hold_first_d;
            hold_icrc_q  <= hold_icrc_d;
            frame_user_q <= frame_user_d;
            s_ready_q    <= ready_early && (state_d != ST_PEND);
            ready_int_q  <= ready_early;
            runt_q       <= runt_d;
            out_valid_q  <= out_valid_d;
            tmp_valid_q  <= tmp_valid_d;
            if (to_out) out_beat_q <= push_beat;
            else if (tmp_to_out) out_beat_q <= tmp_beat_q;
            if (to_tmp) tmp_beat_q <= push_beat;
            if (icrc_fire) icrc_hold_q <= out_icrc;
        end
    end

    assign out_data = out_beat_q[DATA_WIDTH-1:0];
    assign out_keep = out_beat_q[DATA_WIDTH +: KB];
    assign out_last = out_beat_q[DATA_WIDTH+KB];
    assign out_user = out_beat_q[DATA_WIDTH+KB+1 +: USER_WIDTH];
    assign out_icrc = out_beat_q[BW-1 -: 32];

`ifdef ICRC_CHECK_EN
    logic        calc_seen_q, calc_ok, icrc_mismatch;
    logic [31:0] calc_q, calc_val;

    assign calc_ok       = calc_seen_q || s_icrc_calc_valid;
    assign calc_val      = calc_seen_q ? calc_q : s_icrc_calc;
    assign icrc_mismatch = (calc_val != out_icrc);
    assign m_ready_eff   = m_axis_tready && (!out_valid_q || !out_last || calc_ok);
    assign m_axis_tvalid = out_valid_q && (!out_last || calc_ok);
    assign m_axis_tuser  = out_user | USER_WIDTH'(out_last && icrc_mismatch);
    assign m_icrc_bad    = icrc_fire && icrc_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            calc_seen_q <= 1'b0;
            calc_q      <= '0;
        end else if (icrc_fire) begin
            calc_seen_q <= 1'b0;
        end else if (s_icrc_calc_valid && !calc_seen_q) begin
            calc_seen_q <= 1'b1;
            calc_q      <= s_icrc_calc;
        end
    end
`else
    assign m_ready_eff   = m_axis_tready;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tuser  = out_user;
`endif

    assign icrc_fire     = m_axis_tvalid && m_axis_tready && out_last;
    assign s_axis_tready = s_ready_q;
    assign m_axis_tdata  = out_data;
    assign m_axis_tkeep  = out_keep;
    assign m_axis_tlast  = out_last;
    assign m_icrc_valid  = icrc_fire;
    assign m_icrc        = icrc_fire ? out_icrc : icrc_hold_q;
    assign m_runt        = runt_q;

endmodule
